spi_target_sync: RTL and testbench
==================================

// Module: spi_target_sync
// PURPOSE
//  Parametrised SPI target (slave) fully inside the sysclk domain: SPI pins pass 2-flop synchronisers and edges are detected, not used as clocks.
//  Adds word width, SPI mode (CPOL/CPHA), bit order, a TX FIFO with backpressure, underrun/abort flags and a MISO output enable.
//  Sits between the Pi SPI pins and the fan-control register logic.
// PARAMETERS
//  WIDTH        8     bits per SPI word (4..32)
//  CPOL         0     SCLK idle level
//  CPHA         0     0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//  MSB_FIRST    1     1: MSB first on MOSI and MISO; 0: LSB first
//  TX_DEPTH     4     TX FIFO entries, power of 2, >=2
//  IDLE_FILL    'hFF  word shifted out on underrun (truncated to WIDTH)
// PORTS
//  sysclk       in   1      system clock; all logic on posedge; SCLK <= sysclk/8
//  sysreset     in   1      synchronous, active-high reset
//  iSPIClk      in   1      SPI SCLK pin (async)
//  iSPIMOSI     in   1      SPI MOSI pin (async)
//  iSPICS       in   1      SPI chip select, active low (async)
//  oSPIMISO     out  1      MISO data
//  oSPIMISOEn   out  1      1 while CS is asserted (synchronised); for pin tristate
//  oRxValid     out  1      1-cycle pulse: oRx holds a new word
//  oRx          out  WIDTH  last complete received word; held until the next one
//  iTxValid     in   1      push iTx into TX FIFO (accepted only when oTxReady)
//  iTx          in   WIDTH  TX word
//  oTxReady     out  1      TX FIFO not full
//  oTxUnderrun  out  1      1-cycle pulse: word started with FIFO empty
//  oFrameAbort  out  1      1-cycle pulse: CS deasserted with 0 < bit count < WIDTH
// BEHAVIOUR
//  Reset: oSPIMISO=0, oSPIMISOEn=0, oRxValid=0, oRx=0, oTxReady=1, oTxUnderrun=0, oFrameAbort=0; FIFO empty; bit count 0; state IDLE.
//  Sync: each pin through 2 flops; edges found by comparing the synced value with a 3rd flop; latency pin->edge event = 3 sysclk.
//  FSM IDLE: cs_sync high. CS-fall event -> LOAD.
//  FSM LOAD (1 cycle): pop FIFO into shift reg (empty: load IDLE_FILL, pulse oTxUnderrun); CPHA=0: drive first bit on oSPIMISO now; -> ACTIVE.
//  FSM ACTIVE: sample edge: shift MOSI into rx reg, bitcnt+1; shift edge: drive next TX bit (CPHA=1 drives the first bit on the first leading edge).
//  Word end: sample edge with bitcnt==WIDTH-1 -> next cycle oRx=word, oRxValid=1, bitcnt wraps to 0, back-to-back word reloads as in LOAD in the same cycle.
//  Word end timing: the TX reload for CPHA=0 makes bit0 of the next word valid before its first leading edge.
//  CS-rise event in any state -> IDLE next cycle; bitcnt!=0 -> oFrameAbort pulse; partial rx word dropped; popped TX word discarded; oSPIMISOEn=0.
//  Edges of SCLK while cs_sync high are ignored. Sample and shift events on the same cycle cannot occur (edge detector yields one per cycle).
//  FIFO: push when iTxValid&&oTxReady; push while full ignored (no error).
//  FIFO with simultaneous push+pop: both happen. When empty, the pop sees empty (no bypass): underrun fires and the pushed word is stored.
//  FIFO pointers: log2(TX_DEPTH)+1 bits, wrap naturally.
//  Bit order: MSB_FIRST selects shift direction for both rx and tx; the shift register is WIDTH bits and there is no width extension.
//  sysreset mid-frame: everything returns to reset values next cycle. The FSM waits for a fresh CS fall (CS held low after reset gives no LOAD).
// STRUCTURE
//  Package spi_target_pkg: FSM state encoding (IDLE/LOAD/ACTIVE), sync stage count constant, mode-to-edge helper function.
//  Sub-module spi_tx_fifo (WIDTH, TX_DEPTH): sync FIFO, sysclk/sysreset, push/pop/full/empty.
//  Top holds synchronisers, edge detect, FSM, shift regs.
// TESTING
//  Mode 0, WIDTH=8, MSB: master sends 0xA5, FIFO preloaded 0x3C -> oRx=0xA5 with one oRxValid pulse; master reads 0x3C.
//  Burst of 3 words, CS held low, FIFO holds 0x11,0x22,0x33 -> rx 3 pulses in order; MISO 0x11,0x22,0x33; no underrun.
//  Empty FIFO at CS fall -> oTxUnderrun pulse; master reads 0xFF.
//  Push while full (4 entries): 5th push ignored, oTxReady=0; pop restores it.
//  CS rise after 5 bits -> oFrameAbort pulse, no oRxValid; the next full frame receives correctly.
//  Repeat with mode 3, WIDTH=16, LSB_FIRST: 0xBEEF round-trip; sysreset asserted mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared types and helpers for the sysclk-domain SPI target.
package spi_target_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StActive
    } state_e;

    // Flops per pin before the value is considered synchronised.
    localparam int unsigned SyncStages = 2;

    // The leading edge leaves the idle level; CPHA moves sampling to the trailing edge.
    function automatic logic is_sample_edge(input logic cpol, input logic cpha, input logic rise);
        return (rise ^ cpol) ^ cpha;
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous TX FIFO; power-of-two depth, extra pointer bit distinguishes full from empty.
module spi_tx_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(TX_DEPTH);

    logic [WIDTH-1:0] mem_q [TX_DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/spi_target_sync.sv
// SPI target running entirely on sysclk: pins are synchronised and SCLK edges are detected.
module spi_target_sync
    import spi_target_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CPOL      = 0,
    parameter int unsigned CPHA      = 0,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned TX_DEPTH  = 4,
    parameter logic [31:0] IDLE_FILL = 32'hFF
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic             iSPIClk,
    input  logic             iSPIMOSI,
    input  logic             iSPICS,
    output logic             oSPIMISO,
    output logic             oSPIMISOEn,
    output logic             oRxValid,
    output logic [WIDTH-1:0] oRx,
    input  logic             iTxValid,
    input  logic [WIDTH-1:0] iTx,
    output logic             oTxReady,
    output logic             oTxUnderrun,
    output logic             oFrameAbort
);

    localparam int unsigned CntW    = $clog2(WIDTH + 1);
    localparam int unsigned SyncLen = SyncStages + 1;
    localparam logic        CpolL   = (CPOL != 0);
    localparam logic        CphaL   = (CPHA != 0);
    localparam logic        MsbL    = (MSB_FIRST != 0);
    localparam logic [WIDTH-1:0] IdleFillW = IDLE_FILL[WIDTH-1:0];

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MsbL ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return MsbL ? (w << 1) : (w >> 1);
    endfunction

    logic [SyncLen-1:0]    sclk_q, cs_q;
    logic [SyncStages-1:0] mosi_q;
    logic sclk_sync, sclk_edge, mosi_sync, cs_fall, cs_rise;
    logic sample_ev, shift_ev;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  tx_q, tx_d;
    logic [WIDTH-1:0]  rx_q, rx_d, rx_next;
    logic [WIDTH-1:0]  rx_word_q, rx_word_d;
    logic [CntW-1:0]   bitcnt_q, bitcnt_d;
    logic              miso_q, miso_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              abort_q, abort_d;
    logic              reload, fifo_pop, fifo_full, fifo_empty;
    logic [WIDTH-1:0]  fifo_rdata, load_word;

    // CS flops reset low so a CS already held low after reset never looks like a fresh fall.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            sclk_q <= {SyncLen{CpolL}};
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SyncLen-2:0], iSPIClk};
            cs_q   <= {cs_q[SyncLen-2:0], iSPICS};
            mosi_q <= {mosi_q[SyncStages-2:0], iSPIMOSI};
        end
    end

    assign sclk_sync = sclk_q[SyncStages-1];
    assign sclk_edge = sclk_sync ^ sclk_q[SyncStages];
    assign mosi_sync = mosi_q[SyncStages-1];
    assign cs_fall   = !cs_q[SyncStages-1] && cs_q[SyncStages];
    assign cs_rise   = cs_q[SyncStages-1] && !cs_q[SyncStages];
    assign sample_ev = sclk_edge && is_sample_edge(CpolL, CphaL, sclk_sync);
    assign shift_ev  = sclk_edge && !is_sample_edge(CpolL, CphaL, sclk_sync);

    spi_tx_fifo #(
        .WIDTH    (WIDTH),
        .TX_DEPTH (TX_DEPTH)
    ) u_fifo (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .push_i   (iTxValid),
        .wdata_i  (iTx),
        .pop_i    (fifo_pop),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_word_d  = rx_word_q;
        bitcnt_d   = bitcnt_q;
        miso_d     = miso_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        abort_d    = 1'b0;
        reload     = 1'b0;
        fifo_pop   = 1'b0;
        load_word  = fifo_empty ? IdleFillW : fifo_rdata;
        rx_next    = MsbL ? {rx_q[WIDTH-2:0], mosi_sync} : {mosi_sync, rx_q[WIDTH-1:1]};

        if (cs_rise) begin
            state_d  = StIdle;
            abort_d  = (bitcnt_q != '0);
            bitcnt_d = '0;
            rx_d     = '0;
            miso_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) state_d = StLoad;
                end
                StLoad: begin
                    reload  = 1'b1;
                    state_d = StActive;
                end
                StActive: begin
                    if (sample_ev) begin
                        rx_d = rx_next;
                        if (bitcnt_q == CntW'(WIDTH - 1)) begin
                            bitcnt_d   = '0;
                            rx_word_d  = rx_next;
                            rx_valid_d = 1'b1;
                            reload     = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q + CntW'(1);
                        end
                    // CPHA=0: the trailing edge after a word's last sample has nothing new to drive.
                    end else if (shift_ev && (CphaL || bitcnt_q != '0)) begin
                        miso_d = first_bit(tx_q);
                        tx_d   = shift_out(tx_q);
                    end
                end
                default: state_d = StIdle;
            endcase

            if (reload) begin
                fifo_pop   = 1'b1;
                underrun_d = fifo_empty;
                if (CphaL) begin
                    tx_d = load_word;
                end else begin
                    miso_d = first_bit(load_word);
                    tx_d   = shift_out(load_word);
                end
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q    <= StIdle;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_word_q  <= '0;
            bitcnt_q   <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_word_q  <= rx_word_d;
            bitcnt_q   <= bitcnt_d;
            miso_q     <= miso_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            abort_q    <= abort_d;
        end
    end

    assign oSPIMISO    = miso_q;
    assign oSPIMISOEn  = (state_q != StIdle);
    assign oRxValid    = rx_valid_q;
    assign oRx         = rx_word_q;
    assign oTxReady    = !fifo_full;
    assign oTxUnderrun = underrun_q;
    assign oFrameAbort = abort_q;

endmodule

// File: tb/tb_spi_target_sync.sv
// Scoreboard bench: mode 0 / 8-bit / MSB-first and mode 3 / 16-bit / LSB-first targets.
module tb_spi_target_sync;

    localparam int H = 8;  // SCLK half period in sysclk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sclk0 = 1'b0, mosi0 = 1'b0, cs0 = 1'b1;
    logic       miso0, misoen0, rxv0, rdy0, und0, abt0;
    logic       txv0 = 1'b0;
    logic [7:0] rx0;
    logic [7:0] tx0 = '0;

    logic        sclk1 = 1'b1, mosi1 = 1'b0, cs1 = 1'b1;
    logic        miso1, misoen1, rxv1, rdy1, und1, abt1;
    logic        txv1 = 1'b0;
    logic [15:0] rx1;
    logic [15:0] tx1 = '0;

    spi_target_sync u_dut0 (
        .sysclk      (clk),
        .sysreset    (rst),
        .iSPIClk     (sclk0),
        .iSPIMOSI    (mosi0),
        .iSPICS      (cs0),
        .oSPIMISO    (miso0),
        .oSPIMISOEn  (misoen0),
        .oRxValid    (rxv0),
        .oRx         (rx0),
        .iTxValid    (txv0),
        .iTx         (tx0),
        .oTxReady    (rdy0),
        .oTxUnderrun (und0),
        .oFrameAbort (abt0)
    );

    spi_target_sync #(
        .WIDTH     (16),
        .CPOL      (1),
        .CPHA      (1),
        .MSB_FIRST (0)
    ) u_dut1 (
        .sysclk      (clk),
        .sysreset    (rst),
        .iSPIClk     (sclk1),
        .iSPIMOSI    (mosi1),
        .iSPICS      (cs1),
        .oSPIMISO    (miso1),
        .oSPIMISOEn  (misoen1),
        .oRxValid    (rxv1),
        .oRx         (rx1),
        .iTxValid    (txv1),
        .iTx         (tx1),
        .oTxReady    (rdy1),
        .oTxUnderrun (und1),
        .oFrameAbort (abt1)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  q0[$];
    logic [15:0] q1[$];
    int unsigned und0_cnt = 0, abt0_cnt = 0, und1_cnt = 0, abt1_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every oRxValid pulse is matched against the next queued word.
    always @(negedge clk) begin
        if (rxv0) begin
            if (q0.size() == 0) check("rx0_spurious", {24'd0, rx0}, 32'hxxxx_xxxx);
            else check("rx0_word", {24'd0, rx0}, {24'd0, q0.pop_front()});
        end
        if (rxv1) begin
            if (q1.size() == 0) check("rx1_spurious", {16'd0, rx1}, 32'hxxxx_xxxx);
            else check("rx1_word", {16'd0, rx1}, {16'd0, q1.pop_front()});
        end
        if (und0) und0_cnt++;
        if (abt0) abt0_cnt++;
        if (und1) und1_cnt++;
        if (abt1) abt1_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] w);
        txv0 = 1'b1;
        tx0  = w;
        clks(1);
        txv0 = 1'b0;
    endtask

    task automatic push1(input logic [15:0] w);
        txv1 = 1'b1;
        tx1  = w;
        clks(1);
        txv1 = 1'b0;
    endtask

    // Mode 0, MSB first: MOSI set while SCLK low, MISO captured just before the rising edge.
    task automatic m0_bits(input logic [7:0] w, input int nb, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < nb; i++) begin
            mosi0 = w[7-i];
            clks(H);
            r = {r[6:0], miso0};
            sclk0 = 1'b1;
            clks(H);
            sclk0 = 1'b0;
        end
    endtask

    // Mode 3, LSB first: falling edge is leading (shift), rising edge samples.
    task automatic m1_bits(input logic [15:0] w, input int nb, output logic [15:0] r);
        r = '0;
        for (int i = 0; i < nb; i++) begin
            sclk1 = 1'b0;
            mosi1 = w[i];
            clks(H);
            r[i] = miso1;
            sclk1 = 1'b1;
            clks(H);
        end
    endtask

    task automatic frame0_start();
        cs0 = 1'b0;
        clks(8);
    endtask

    task automatic frame0_end();
        clks(H);
        cs0 = 1'b1;
        clks(8);
    endtask

    task automatic frame1_start();
        cs1 = 1'b0;
        clks(8);
    endtask

    task automatic frame1_end();
        cs1 = 1'b1;
        clks(8);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r8;
        logic [15:0] r16;
        int unsigned und_s, abt_s;

        clks(3);
        rst = 1'b0;
        clks(2);

        check("rst_miso0",   {31'd0, miso0},   32'd0);
        check("rst_misoen0", {31'd0, misoen0}, 32'd0);
        check("rst_rx0",     {24'd0, rx0},     32'd0);
        check("rst_rdy0",    {31'd0, rdy0},    32'd1);
        check("rst_und0",    {31'd0, und0},    32'd0);
        check("rst_abt0",    {31'd0, abt0},    32'd0);
        check("rst_rdy1",    {31'd0, rdy1},    32'd1);
        check("rst_misoen1", {31'd0, misoen1}, 32'd0);

        // Single word 0xA5 in, 0x3C out; end-of-word reload finds the FIFO empty.
        push0(8'h3C);
        und_s = und0_cnt;
        q0.push_back(8'hA5);
        frame0_start();
        check("misoen0_active", {31'd0, misoen0}, 32'd1);
        m0_bits(8'hA5, 8, r8);
        check("m0_read_3c", {24'd0, r8}, 32'h3C);
        frame0_end();
        check("und0_single", und0_cnt - und_s, 32'd1);
        check("misoen0_idle", {31'd0, misoen0}, 32'd0);

        // Burst of three; a fourth entry covers the reload after the last word.
        push0(8'h11);
        push0(8'h22);
        push0(8'h33);
        push0(8'h44);
        und_s = und0_cnt;
        frame0_start();
        q0.push_back(8'h01);
        m0_bits(8'h01, 8, r8);
        check("burst_miso0", {24'd0, r8}, 32'h11);
        q0.push_back(8'h80);
        m0_bits(8'h80, 8, r8);
        check("burst_miso1", {24'd0, r8}, 32'h22);
        q0.push_back(8'h7E);
        m0_bits(8'h7E, 8, r8);
        check("burst_miso2", {24'd0, r8}, 32'h33);
        frame0_end();
        check("burst_no_underrun", und0_cnt - und_s, 32'd0);

        // Empty FIFO: underrun at CS fall and again at the end-of-word reload.
        und_s = und0_cnt;
        q0.push_back(8'h5A);
        frame0_start();
        m0_bits(8'h5A, 8, r8);
        frame0_end();
        check("underrun_fill", {24'd0, r8}, 32'hFF);
        check("underrun_cnt", und0_cnt - und_s, 32'd2);

        // Full FIFO ignores a fifth push.
        push0(8'h01);
        push0(8'h02);
        push0(8'h03);
        push0(8'h04);
        check("full_rdy0", {31'd0, rdy0}, 32'd0);
        push0(8'h99);
        check("full_rdy0_after5", {31'd0, rdy0}, 32'd0);
        q0.push_back(8'hF0);
        frame0_start();
        m0_bits(8'hF0, 8, r8);
        frame0_end();
        check("full_first_out", {24'd0, r8}, 32'h01);
        check("pop_rdy0", {31'd0, rdy0}, 32'd1);
        q0.push_back(8'h0F);
        frame0_start();
        m0_bits(8'h0F, 8, r8);
        frame0_end();
        check("full_third_out", {24'd0, r8}, 32'h03);

        // Abort after five bits, then a clean frame.
        abt_s = abt0_cnt;
        frame0_start();
        m0_bits(8'hAA, 5, r8);
        frame0_end();
        check("abort_cnt", abt0_cnt - abt_s, 32'd1);
        q0.push_back(8'hC3);
        frame0_start();
        m0_bits(8'hC3, 8, r8);
        frame0_end();
        check("after_abort_miso", {24'd0, r8}, 32'hFF);
        check("after_abort_no_abort", abt0_cnt - abt_s, 32'd1);

        // Mode 3, 16-bit, LSB first.
        push1(16'hBEEF);
        q1.push_back(16'hBEEF);
        frame1_start();
        m1_bits(16'hBEEF, 16, r16);
        frame1_end();
        check("m3_read_beef", {16'd0, r16}, 32'hBEEF);
        push1(16'hCAFE);
        q1.push_back(16'h1234);
        frame1_start();
        m1_bits(16'h1234, 16, r16);
        frame1_end();
        check("m3_read_cafe", {16'd0, r16}, 32'hCAFE);

        // Reset mid-frame with CS held low afterwards.
        push1(16'h5555);
        abt_s = abt1_cnt;
        frame1_start();
        m1_bits(16'hFFFF, 6, r16);
        rst = 1'b1;
        clks(1);
        check("mid_rst_miso1",   {31'd0, miso1},   32'd0);
        check("mid_rst_misoen1", {31'd0, misoen1}, 32'd0);
        check("mid_rst_rxv1",    {31'd0, rxv1},    32'd0);
        check("mid_rst_rx1",     {16'd0, rx1},     32'd0);
        check("mid_rst_und1",    {31'd0, und1},    32'd0);
        check("mid_rst_abt1",    {31'd0, abt1},    32'd0);
        check("mid_rst_rdy1",    {31'd0, rdy1},    32'd1);
        rst = 1'b0;
        clks(2);
        m1_bits(16'hA5A5, 16, r16);
        check("cs_low_after_rst_en", {31'd0, misoen1}, 32'd0);
        frame1_end();
        check("cs_low_after_rst_abort", abt1_cnt - abt_s, 32'd0);
        q1.push_back(16'h0F0F);
        frame1_start();
        m1_bits(16'h0F0F, 16, r16);
        frame1_end();
        check("m3_fill_truncated", {16'd0, r16}, 32'h00FF);

        clks(4);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
